// File: rtl/exe_alu_seq.sv
// exe_alu_seq: handshaked execute-stage ALU.
// Single-cycle AND/OR/ADD/SUB/SLT/NOR; unknown opcodes return 0.
// Iterative unsigned MUL/DIVU/REMU are built only when EXE_ALU_MULDIV_EN is
// defined. Without it, those opcodes behave like the legacy ALU: a single-cycle
// result of 0.
//
// state | meaning
// IDLE  | no result held, ready for a new operation
// BUSY  | multi-cycle iteration in progress, cnt counts down to 0
// DONE  | result registers valid, waiting for out_ready
module exe_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_operation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             Zero,
    output logic             Overflow
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b0101;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q;
    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;

    logic             accept;
    logic             is_multi;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;

    assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = valid_q;
    assign ALU_result = result_q;
    assign Zero       = zero_q;
    assign Overflow   = ovf_q;

    assign sum     = A + B;
    assign diff    = A - B;
    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

    // Single-cycle result and overflow; SLT is corrected by the SUB overflow.
    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (ALU_operation)
            OP_AND: sc_res = A & B;
            OP_OR:  sc_res = A | B;
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = add_ovf;
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = sub_ovf;
            end
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            OP_NOR: sc_res = ~(A | B);
            default: sc_res = '0;
        endcase
    end

`ifdef EXE_ALU_MULDIV_EN
    localparam int CW = $clog2(WIDTH);

    // acc_q: product accumulator or partial remainder.
    // opa_q: shifted multiplicand or dividend/quotient shift register.
    // opb_q: shifted multiplier or divisor.
    logic [CW-1:0]    cnt_q;
    logic             mul_q;
    logic             rem_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] opa_d;
    logic [WIDTH-1:0] opb_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] iter_res;

    assign is_multi = (ALU_operation == OP_MUL) || (ALU_operation == OP_DIVU) ||
                      (ALU_operation == OP_REMU);

    // One shift-add or restoring-division step. A zero divisor always passes
    // the trial compare, giving an all-ones quotient and remainder == A.
    always_comb begin
        trial = {acc_q, opa_q[WIDTH-1]};
        acc_d = acc_q;
        opa_d = opa_q;
        opb_d = opb_q;
        if (mul_q) begin
            acc_d = opb_q[0] ? (acc_q + opa_q) : acc_q;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
        end else if (trial >= {1'b0, opb_q}) begin
            acc_d = trial[WIDTH-1:0] - opb_q;
            opa_d = {opa_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = trial[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], 1'b0};
        end
        iter_res = (mul_q || rem_q) ? acc_d : opa_d;
    end
`else
    assign is_multi = 1'b0;
`endif

    // Control FSM with registered result, flags and iteration datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
`ifdef EXE_ALU_MULDIV_EN
            cnt_q    <= '0;
            mul_q    <= 1'b0;
            rem_q    <= 1'b0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (is_multi) begin
                            state_q <= S_BUSY;
                            valid_q <= 1'b0;
`ifdef EXE_ALU_MULDIV_EN
                            cnt_q   <= CW'(WIDTH - 1);
                            mul_q   <= (ALU_operation == OP_MUL);
                            rem_q   <= (ALU_operation == OP_REMU);
                            acc_q   <= '0;
                            opa_q   <= A;
                            opb_q   <= B;
`endif
                        end else begin
                            state_q  <= S_DONE;
                            valid_q  <= 1'b1;
                            result_q <= sc_res;
                            zero_q   <= (sc_res == '0);
                            ovf_q    <= sc_ovf;
                        end
                    end else if ((state_q == S_DONE) && out_ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                S_BUSY: begin
`ifdef EXE_ALU_MULDIV_EN
                    acc_q <= acc_d;
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                    if (cnt_q == '0) begin
                        state_q  <= S_DONE;
                        valid_q  <= 1'b1;
                        result_q <= iter_res;
                        zero_q   <= (iter_res == '0);
                        ovf_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
`else
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_alu_seq.sv
// Bench for exe_alu_seq, WIDTH=32. Expectations for MUL/DIVU/REMU follow
// whether EXE_ALU_MULDIV_EN is defined for the build.
module tb_exe_alu_seq;

`ifdef EXE_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int ML = MD ? 32 : 0;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b0101;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        zero;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    exe_alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_operation(op), .A(a), .B(b), .out_valid(out_valid),
        .out_ready(out_ready), .ALU_result(res), .Zero(zero), .Overflow(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] r, input logic v, input int l);
        vec_t t;
        t.op = o; t.a = x; t.b = y; t.res = r; t.zero = (r == 32'd0); t.ovf = v; t.lat = l;
        return t;
    endfunction

    // Multi-cycle ops: full result when the iterative unit is built, else 0 in one cycle.
    function automatic vec_t mkm(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] r);
        return mk(o, x, y, MD ? r : 32'd0, 1'b0, ML);
    endfunction

    task automatic run_op(input vec_t v, input int idx);
        int  n;
        int  lat;
        bit  busy_ok;
        @(negedge clk);
        op = v.op; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("vec%0d_ready", idx), {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 4'hF; a = $urandom; b = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("vec%0d_latency", idx), lat, v.lat);
        chk($sformatf("vec%0d_busy_in_ready_low", idx), {31'd0, busy_ok}, 32'd1);
        chk($sformatf("vec%0d_result", idx), res, v.res);
        chk($sformatf("vec%0d_zero", idx), {31'd0, zero}, {31'd0, v.zero});
        chk($sformatf("vec%0d_overflow", idx), {31'd0, ovf}, {31'd0, v.ovf});
    endtask

    initial begin
        bit ok;
        bit seen;

        vecs[0]  = mk(OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 0);
        vecs[1]  = mk(OP_OR,  32'h1200_0034, 32'h0000_5600, 32'h1200_5634, 1'b0, 0);
        vecs[2]  = mk(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 0);
        vecs[3]  = mk(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 0);
        vecs[4]  = mk(OP_SUB, 32'd5,         32'd5,         32'h0000_0000, 1'b0, 0);
        vecs[5]  = mk(OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 0);
        vecs[6]  = mk(OP_SLT, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 0);
        vecs[7]  = mk(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 0);
        vecs[8]  = mk(OP_NOR, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 1'b0, 0);
        vecs[9]  = mk(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 0);
        vecs[10] = mkm(OP_MUL,  32'h0001_0003, 32'h0000_0100, 32'h0100_0300);
        vecs[11] = mkm(OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        vecs[12] = mkm(OP_DIVU, 32'd100, 32'd7, 32'd14);
        vecs[13] = mkm(OP_REMU, 32'd100, 32'd7, 32'd2);
        vecs[14] = mkm(OP_DIVU, 32'd5,   32'd0, 32'hFFFF_FFFF);
        vecs[15] = mkm(OP_REMU, 32'd5,   32'd0, 32'd5);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; a = '0; b = '0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", res, 32'd0);
        chk("reset_zero", {31'd0, zero}, 32'd1);
        chk("reset_overflow", {31'd0, ovf}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 16; i++) run_op(vecs[i], i);

        // Back-to-back ADD, SUB, SLT with out_ready held high.
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        op = OP_ADD; a = 32'h7FFF_FFFF; b = 32'd1;
        @(posedge clk);
        #1;
        chk("b2b_add_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_add_result", res, 32'h8000_0000);
        chk("b2b_add_overflow", {31'd0, ovf}, 32'd1);
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        op = OP_SUB; a = 32'd5; b = 32'd5;
        @(posedge clk);
        #1;
        chk("b2b_sub_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_sub_result", res, 32'd0);
        chk("b2b_sub_zero", {31'd0, zero}, 32'd1);
        op = OP_SLT; a = 32'h8000_0000; b = 32'd1;
        @(posedge clk);
        #1;
        chk("b2b_slt_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_slt_result", res, 32'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: OR result held while an AND waits.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        op = OP_OR; a = 32'h0000_00F0; b = 32'h0F00_0000;
        @(posedge clk);
        #1;
        chk("bp_or_result", res, 32'h0F00_00F0);
        op = OP_AND; a = 32'hFF00_FF00; b = 32'h0FF0_0FF0;
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (in_ready) ok = 1'b0;
            @(posedge clk);
            #1;
            if (!out_valid || res !== 32'h0F00_00F0) ok = 1'b0;
        end
        chk("bp_hold_stable", {31'd0, ok}, 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_follows_out_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("bp_and_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_and_result", res, 32'h0F00_0F00);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset 10 cycles into a DIVU; the aborted op must never deliver.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        op = OP_DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== !MD) ok = 1'b0;
        end
        chk("abort_pre_reset_valid", {31'd0, ok}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", {31'd0, seen}, 32'd0);
        run_op(mk(OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 0), 99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exe_alu_seq.md
# exe_alu_seq

Parametrised, handshaked successor to the combinational execute-stage ALU. Keeps the existing 4-bit operation encoding and the single-cycle AND/OR/ADD/SUB/SLT behaviour, and adds NOR plus iterative unsigned multiply, divide and remainder. Operands are accepted with a valid/ready handshake and results are returned through an output register. It sits in the EXE stage between operand fetch and write-back and can stall the pipeline through `in_ready`.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; must be ≥ 4.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous and active-high.
- `in_valid` in 1: operands and operation are valid.
- `in_ready` out 1: unit can accept an operation this cycle.
- `ALU_operation` in 4: operation code (see Operation).
- `A` in WIDTH: operand A.
- `B` in WIDTH: operand B.
- `out_valid` out 1: result registers hold a valid result.
- `out_ready` in 1: consumer takes the result this cycle.
- `ALU_result` out WIDTH: result.
- `Zero` out 1: high when `ALU_result` is all zeros.
- `Overflow` out 1: signed overflow of ADD/SUB; 0 for all other operations.

## Operation
- Opcodes, single-cycle unless marked:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD, modulo 2^WIDTH.
  - 0110 SUB, A−B modulo 2^WIDTH.
  - 0111 SLT: result is 1 if A<B signed, else 0. Overflow-corrected, so the result is (A−B)[MSB] XOR overflow.
  - 1100 NOR.
  - 0011 MUL, multi: low WIDTH bits of A×B.
  - 0100 DIVU, multi: A/B unsigned.
  - 0101 REMU, multi: A%B unsigned.
  - Every other code: result 0, single-cycle.
- Division by zero: DIVU returns all ones; REMU returns A. Both still take the full multi-cycle latency.
- MUL is shift-add, one bit per cycle. DIVU/REMU use restoring division, one bit per cycle.
- Operands are captured at accept. Later changes on `A`, `B` or `ALU_operation` do not affect an operation in flight.
- `Zero` and `Overflow` are registered together with `ALU_result`.
- State machine:
  - IDLE:
    - Accepting a single-cycle op moves to DONE.
    - Accepting a multi-cycle op moves to BUSY with `cnt` = WIDTH−1.
  - BUSY:
    - Performs one iteration per cycle.
    - When `cnt` = 0, writes the result and moves to DONE; otherwise decrements `cnt`.
  - DONE:
    - `out_valid` = 1.
    - If `out_ready` and `in_valid`, accept the new operation, with the same transition as from IDLE.
    - If `out_ready` and not `in_valid`, return to IDLE.
    - If not `out_ready`, hold. Result, `Zero` and `Overflow` stay stable.
- `in_ready` = (state==IDLE) OR (state==DONE AND `out_ready`). It is a combinational function of state and `out_ready` only; there is no path from `in_valid`.

## Timing
- Reset values: state IDLE, `out_valid` 0, `ALU_result` 0, `Zero` 1, `Overflow` 0, `cnt` 0. `in_ready` is 1 one cycle after `rst` deasserts.
- `rst` has priority over everything. Reset during BUSY or DONE aborts the operation; no result is delivered.
- Accept occurs on a rising edge where `in_valid` AND `in_ready`.
- Single-cycle op accepted at edge N: `out_valid` is high from edge N, visible in cycle N+1.
- Multi-cycle op accepted at edge N: BUSY for edges N+1…N+WIDTH. The result is written and `out_valid` rises at edge N+WIDTH.
- Back-to-back single-cycle ops with `out_ready` held high give one result per cycle.
- An operation is never lost or duplicated. A result is consumed exactly once, at an edge with `out_valid` AND `out_ready`.

## Configuration
- `EXE_ALU_MULDIV_EN` defined: MUL, DIVU and REMU are implemented as specified, and the iteration datapath is present.
- `EXE_ALU_MULDIV_EN` undefined:
  - Opcodes 0011/0100/0101 are single-cycle and return 0 with `Zero` = 1, matching the legacy ALU.
  - No multiplier/divider registers and no `cnt` are present.
  - BUSY is unreachable.

## Test plan
All scenarios use WIDTH=32.
- Reset: hold `rst` for 3 cycles, then release. Required: `out_valid`=0, `ALU_result`=0, `Zero`=1, `in_ready`=1.
- ADD/SUB overflow, `out_ready` held at 1:
  - ADD 0x7FFFFFFF+1 returns 0x80000000, `Overflow`=1.
  - SUB 5−5 returns 0, `Zero`=1.
  - SLT 0x80000000 vs 1 returns 1.
  - The three results come back on consecutive cycles.
- MUL: 0x0001_0003×0x0000_0100 returns 0x0100_0300. `out_valid` rises exactly 32 edges after accept, and `in_ready`=0 throughout BUSY.
- Division:
  - DIVU 100/7 returns 14; REMU 100/7 returns 2.
  - DIVU 5/0 returns 0xFFFFFFFF; REMU 5/0 returns 5.
- Backpressure: hold `out_ready`=0 for 5 cycles after an OR result. Required: `ALU_result` stable, `in_ready`=0, and no new accept. Then raise `out_ready` with a pending AND: AND is accepted on the same edge, and its result appears the next cycle.
- Reset mid-BUSY: assert `rst` 10 cycles into a DIVU. Required: IDLE next cycle, `out_valid` never asserted for the aborted op. A following ADD 2+3 returns 5.
